// File: rtl/if_id_latch.sv
// IF/ID pipeline register with load-use stall detection and flush insertion, plus saturating stall/flush counters.
// One-cycle latency IF->ID; a load-use hazard holds the latch and raises stop_IF/bubble_EX combinationally.
module if_id_latch #(
    parameter int WIDTH_INST = 32,
    parameter int WIDTH_PC   = 32,
    parameter int WIDTH_CNT  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH_INST-1:0] inst_IF,
    input  logic [WIDTH_PC-1:0]   pc_IF,
    input  logic                  risk_Ctrl,
    input  logic                  memread_EX,
    input  logic [4:0]            rd_EX,
    output logic [WIDTH_INST-1:0] inst_ID,
    output logic [WIDTH_PC-1:0]   pc_ID,
    output logic                  valid_ID,
    output logic                  stop_IF,
    output logic                  bubble_EX,
    output logic [WIDTH_CNT-1:0]  stall_cnt,
    output logic [WIDTH_CNT-1:0]  flush_cnt
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    logic [WIDTH_INST-1:0] inst_q, inst_d;
    logic [WIDTH_PC-1:0]   pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [WIDTH_CNT-1:0]  stall_q, stall_d;
    logic [WIDTH_CNT-1:0]  flush_q, flush_d;

    logic [4:0] rs1, rs2;
    logic [6:0] opcode;
    logic       rs1_used, rs2_used, hazard;

    assign rs1    = inst_q[19:15];
    assign rs2    = inst_q[24:20];
    assign opcode = inst_q[6:0];

    assign rs1_used = (inst_q != '0) && (opcode != OP_LUI) &&
                      (opcode != OP_AUIPC) && (opcode != OP_JAL);
    assign rs2_used = (opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B);

    // valid_q is cleared in reset and on bubbles, so x0 and non-instructions never stall
    assign hazard = valid_q && memread_EX && (rd_EX != 5'd0) &&
                    ((rs1_used && (rs1 == rd_EX)) || (rs2_used && (rs2 == rd_EX)));

    always_comb begin
        inst_d  = inst_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (hazard) begin
            if (stall_q != '1) stall_d = stall_q + WIDTH_CNT'(1);
        end else if (risk_Ctrl) begin
            inst_d  = '0;
            pc_d    = pc_IF;
            valid_d = 1'b0;
            if (flush_q != '1) flush_d = flush_q + WIDTH_CNT'(1);
        end else begin
            inst_d  = inst_IF;
            pc_d    = pc_IF;
            valid_d = (inst_IF != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign inst_ID   = inst_q;
    assign pc_ID     = pc_q;
    assign valid_ID  = valid_q;
    assign stop_IF   = hazard;
    assign bubble_EX = hazard;
    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;

endmodule
